segment_mode_controller: RTL
============================

SEGMENT_MODE_CONTROLLER -- requirements
Module: segment_mode_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required to accept a button level change.
REQ-002 Parameter IDLE_TIMEOUT, default 500000000: cycles without a button press or switch change before the display blanks.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Buttons  input  3  raw mechanical buttons, active-low, asynchronous to clk.
REQ-006 Switches  input  4  raw binary value switches, asynchronous to clk.
REQ-007 ModeCode  output  3  registered mode word for the segment decoder: 3'b011 hex, 3'b101 BCD, 3'b110 decimal, 3'b111 blank.
REQ-008 SwitchesOut  output  4  registered, synchronized copy of Switches.
REQ-009 ModeChange  output  1  one-cycle pulse, asserted in the first cycle ModeCode holds a new value.

Function
REQ-010 Each Buttons bit and each Switches bit SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each synchronized button SHALL have a debounced level; it flips only after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears that bit's counter.
REQ-012 A press event SHALL be a debounced 1->0 transition, one cycle wide; releases generate no event.
REQ-013 FSM states SHALL be BLANK, HEX, BCD, DEC; ModeCode SHALL be the state's encoding from REQ-007.
REQ-014 Press on Buttons[2] -> HEX, Buttons[1] -> BCD, Buttons[0] -> DEC; the state SHALL update on the clock edge after the event cycle.
REQ-015 A press selecting the current state SHALL move the FSM to BLANK (toggle-off).
REQ-016 Simultaneous press events SHALL resolve by priority Buttons[2] > Buttons[1] > Buttons[0]; lower-priority events in that cycle are discarded.
REQ-017 SwitchesOut SHALL update every cycle from the second synchronizer stage; a switch change is SwitchesOut differing from its previous-cycle value.
REQ-018 The idle counter SHALL clear on any press event or switch change, otherwise increment, saturating at IDLE_TIMEOUT.
REQ-019 When the idle counter reaches IDLE_TIMEOUT in a non-BLANK state, the FSM SHALL go to BLANK on the next edge; in BLANK, the counter SHALL hold at zero.
REQ-020 A press event in the same cycle as timeout SHALL take precedence over the timeout.
REQ-021 ModeChange SHALL pulse only when ModeCode actually changes value, including a timeout to BLANK.
REQ-022 Total press latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (event) + 1 (state) cycles from the first stable low raw sample.
REQ-023 Counter widths SHALL be $clog2(parameter+1); no counter may wrap.

Reset
REQ-024 With rst_n low: state BLANK, ModeCode 3'b111, SwitchesOut 4'b0000, ModeChange 0.
REQ-025 Reset SHALL set synchronizers to 1 for Buttons and 0 for Switches, debounced levels to 1, and all counters to 0.
REQ-026 Reset asserted mid-debounce or mid-press SHALL discard the pending event; a button held low through reset release SHALL produce a press after the full REQ-022 latency.

Structure
REQ-027 Mode encodings, the FSM state type and the default parameter values SHALL live in shared package segment_pkg, also used by the display decoder.
REQ-028 A single-bit synchronizer plus debouncer SHALL be sub-module button_debounce (parameter DEBOUNCE_CYCLES; outputs level and fall-pulse), instantiated three times.

Verification (bench: DEBOUNCE_CYCLES=4, IDLE_TIMEOUT=100)
REQ-029 Reset release, Buttons=3'b111 -> ModeCode 3'b111, ModeChange 0 for 200 cycles.
REQ-030 Buttons[2] held low -> ModeCode 3'b011 exactly 8 cycles after the first low sample, with a 1-cycle ModeChange; a second press -> 3'b111.
REQ-031 Buttons[1] toggled every 2 cycles for 40 cycles, then released -> no event, ModeCode unchanged.
REQ-032 Buttons[2] and Buttons[0] go low in the same cycle -> ModeCode 3'b011 only.
REQ-033 In DEC, Switches 4'h3->4'h9 at cycle 60 after the last press -> blank at cycle 160+, not cycle 100; with no changes, blank 100 cycles after the last event.
REQ-034 rst_n pulsed low 2 cycles into a debounce with Buttons[1] held low -> ModeCode 3'b111 immediately; 3'b101 8 cycles after reset release.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared mode encodings and defaults for the segment display path.
// Also used by the downstream segment decoder.
package segment_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int IDLE_TIMEOUT_DEF    = 500000000;

    localparam logic [2:0] MODE_HEX   = 3'b011;
    localparam logic [2:0] MODE_BCD   = 3'b101;
    localparam logic [2:0] MODE_DEC   = 3'b110;
    localparam logic [2:0] MODE_BLANK = 3'b111;

    // State encoding equals the mode word, so ModeCode is the state register.
    typedef enum logic [2:0] {
        ST_BLANK = MODE_BLANK,
        ST_HEX   = MODE_HEX,
        ST_BCD   = MODE_BCD,
        ST_DEC   = MODE_DEC
    } mode_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer and counter debouncer for one active-low button.
// Emits the debounced level and a one-cycle pulse on a debounced fall.
module button_debounce
    import segment_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level_prev;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          done;

    assign differ = (sync2 != level);
    assign done   = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Synchronize, count disagreeing samples, flip level, detect the fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            level      <= 1'b1;
            level_prev <= 1'b1;
            fall       <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            level_prev <= level;
            fall       <= level_prev & ~level;
            if (!differ) begin
                cnt <= '0;
            end else if (done) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/segment_mode_controller.sv
// Button-driven display mode FSM with switch passthrough and idle blanking.
// Mode word is registered; ModeChange marks the first cycle of a new mode.
module segment_mode_controller
    import segment_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int IDLE_TIMEOUT    = IDLE_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] Buttons,
    input  logic [3:0] Switches,
    output logic [2:0] ModeCode,
    output logic [3:0] SwitchesOut,
    output logic       ModeChange
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic [2:0]  btn_level;
    logic [2:0]  btn_fall;
    logic        unused_level;
    logic [3:0]  sw_sync1;
    logic [3:0]  sw_sync2;
    logic [3:0]  sw_prev;
    logic        sw_change;
    logic        press;
    mode_state_t state_q;
    mode_state_t state_d;
    mode_state_t sel;
    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (Buttons[i]),
            .level(btn_level[i]),
            .fall (btn_fall[i])
        );
    end

    assign unused_level = ^btn_level;
    assign sw_change    = (SwitchesOut != sw_prev);
    assign press        = |btn_fall;
    assign ModeCode     = state_q;

    // Switch synchronizer and one-cycle history for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1    <= '0;
            sw_sync2    <= '0;
            SwitchesOut <= '0;
            sw_prev     <= '0;
        end else begin
            sw_sync1    <= Switches;
            sw_sync2    <= sw_sync1;
            SwitchesOut <= sw_sync2;
            sw_prev     <= SwitchesOut;
        end
    end

    // Next mode: prioritized press with toggle-off, else idle timeout.
    always_comb begin
        state_d = state_q;
        sel     = state_q;
        idle_d  = idle_q;
        if (btn_fall[2]) begin
            sel = ST_HEX;
        end else if (btn_fall[1]) begin
            sel = ST_BCD;
        end else if (btn_fall[0]) begin
            sel = ST_DEC;
        end
        if (press) begin
            state_d = (sel == state_q) ? ST_BLANK : sel;
        end else if (state_q != ST_BLANK &&
                     idle_q == IW'(IDLE_TIMEOUT)) begin
            state_d = ST_BLANK;
        end
        if (press || sw_change || state_q == ST_BLANK) begin
            idle_d = '0;
        end else if (idle_q != IW'(IDLE_TIMEOUT)) begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Mode, idle counter and change pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            idle_q     <= '0;
            ModeChange <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            ModeChange <= (state_d != state_q);
        end
    end

endmodule
